// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register built as an elastic stage. A main entry drives the outputs and a
// skid entry catches one beat under back-pressure. Also provides a forwarding port and a stall counter.
module mem_wb_stage #(
    parameter int DATA_W        = 32,
    parameter int REG_AW        = 5,
    parameter int CNT_W         = 16,
    parameter int ZERO_REG_KILL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] outE,
    input  logic [DATA_W-1:0] Dataout,
    input  logic [REG_AW-1:0] RegEscr1E,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] outE_M,
    output logic [DATA_W-1:0] DataoutM,
    output logic [REG_AW-1:0] RegEscr1E_M,
    output logic              reg_write_q,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                in_ready_r;
    logic                in_ready_nxt_s;
    logic                out_valid_r;
    logic                accept_s;
    logic                pop_s;
    logic                load_main_s;
    logic                load_skid_s;
    logic                main_from_skid_s;
    logic                in_wr_s;

    logic [DATA_W-1:0]   main_alu_r;
    logic [DATA_W-1:0]   main_ld_r;
    logic [REG_AW-1:0]   main_rd_r;
    logic                main_wr_r;
    logic                main_m2r_r;
    logic [DATA_W-1:0]   skid_alu_r;
    logic [DATA_W-1:0]   skid_ld_r;
    logic [REG_AW-1:0]   skid_rd_r;
    logic                skid_wr_r;
    logic                skid_m2r_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    // Writes to r0 are killed on entry so reg_write_q is a plain register output.
    function automatic logic gate_wr(input logic wr, input logic [REG_AW-1:0] rd);
        return wr & ~((ZERO_REG_KILL != 0) && (rd == {REG_AW{1'b0}}));
    endfunction

    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;
    assign in_wr_s  = gate_wr(reg_write, RegEscr1E);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush empties the stage regardless of handshake.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) state_nxt_s = ST_ONE;
                    else          state_nxt_s = ST_EMPTY;
                end
                ST_ONE: begin
                    if (accept_s && !pop_s)      state_nxt_s = ST_TWO;
                    else if (!accept_s && pop_s) state_nxt_s = ST_EMPTY;
                    else                         state_nxt_s = ST_ONE;
                end
                ST_TWO: begin
                    if (pop_s) state_nxt_s = ST_ONE;
                    else       state_nxt_s = ST_TWO;
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Datapath load controls and the next value of in_ready.
    always_comb begin
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            load_main_s      = 1'b0;
            load_skid_s      = 1'b0;
            main_from_skid_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: load_main_s = accept_s;
                ST_ONE: begin
                    if (accept_s) begin
                        load_main_s = pop_s;
                        load_skid_s = ~pop_s;
                    end else begin
                        load_main_s = 1'b0;
                    end
                end
                ST_TWO:  main_from_skid_s = pop_s;
                default: load_main_s = 1'b0;
            endcase
        end
        if (state_nxt_s != ST_TWO) in_ready_nxt_s = 1'b1;
        else                       in_ready_nxt_s = 1'b0;
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Main (head) entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_alu_r <= {DATA_W{1'b0}};
            main_ld_r  <= {DATA_W{1'b0}};
            main_rd_r  <= {REG_AW{1'b0}};
            main_wr_r  <= 1'b0;
            main_m2r_r <= 1'b0;
        end else if (main_from_skid_s) begin
            main_alu_r <= skid_alu_r;
            main_ld_r  <= skid_ld_r;
            main_rd_r  <= skid_rd_r;
            main_wr_r  <= skid_wr_r;
            main_m2r_r <= skid_m2r_r;
        end else if (load_main_s) begin
            main_alu_r <= outE;
            main_ld_r  <= Dataout;
            main_rd_r  <= RegEscr1E;
            main_wr_r  <= in_wr_s;
            main_m2r_r <= mem_to_reg;
        end else begin
            main_alu_r <= main_alu_r;
            main_ld_r  <= main_ld_r;
            main_rd_r  <= main_rd_r;
            main_wr_r  <= main_wr_r;
            main_m2r_r <= main_m2r_r;
        end
    end

    // Skid entry, filled only by an accept that cannot be popped through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_alu_r <= {DATA_W{1'b0}};
            skid_ld_r  <= {DATA_W{1'b0}};
            skid_rd_r  <= {REG_AW{1'b0}};
            skid_wr_r  <= 1'b0;
            skid_m2r_r <= 1'b0;
        end else if (load_skid_s) begin
            skid_alu_r <= outE;
            skid_ld_r  <= Dataout;
            skid_rd_r  <= RegEscr1E;
            skid_wr_r  <= in_wr_s;
            skid_m2r_r <= mem_to_reg;
        end else begin
            skid_alu_r <= skid_alu_r;
            skid_ld_r  <= skid_ld_r;
            skid_rd_r  <= skid_rd_r;
            skid_wr_r  <= skid_wr_r;
            skid_m2r_r <= skid_m2r_r;
        end
    end

    // Saturating count of cycles the head is held by writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign outE_M      = main_alu_r;
    assign DataoutM    = main_ld_r;
    assign RegEscr1E_M = main_rd_r;
    assign reg_write_q = main_wr_r;
    assign stall_cnt   = stall_cnt_r;
    assign wb_data     = main_m2r_r ? main_ld_r : main_alu_r;
    assign fwd_valid   = out_valid_r & main_wr_r;
    assign fwd_rd      = main_rd_r;
    assign fwd_data    = wb_data;

endmodule
